f1_race_ctrl: RTL and testbench

- Sequencer for the F1 start-light FSM (`f1_fsm`). It drives `trigger` and `en`, pacing the light-up sequence at a fixed tick rate.
- It inserts a pseudo-random hold before lights-out, then measures driver reaction time in clock cycles.
- It detects false starts (button pressed before lights-out) and holds the light FSM cleared until re-armed.
- It sits between the board button/clock and `f1_fsm`. Its reaction-time result goes to the display path.

---
 rtl/f1_pkg.sv | 16 +
 rtl/f1_lfsr.sv | 26 ++
 rtl/f1_race_ctrl.sv | 148 ++++++++++++++
 tb/tb_f1_race_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and LFSR constants for the F1 start-light controller
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEQ,
        DELAY,
        TIMING,
        FAULT
    } ctrl_state_t;

    // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of a left-shifting register)
    localparam logic [6:0] LFSR_TAPS = 7'b110_0000;
    localparam logic [6:0] LFSR_SEED = 7'd1;

endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running Fibonacci LFSR supplying the random lights-out hold
module f1_lfsr
    import f1_pkg::*;
#(
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] q_o
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    logic [LFSR_W-1:0] q_q, q_d;

    // Shift left, feeding back the XOR of the tapped bits; a nonzero seed never reaches 0
    always_comb q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};

    // Advance every cycle regardless of the controller state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= LFSR_W'(LFSR_SEED);
        else        q_q <= q_d;

    assign q_o = q_q;

endmodule

// File: rtl/f1_race_ctrl.sv
// f1_race_ctrl: paces the start lights, inserts a random hold, times the driver and flags false starts
module f1_race_ctrl
    import f1_pkg::*;
#(
    parameter int TICK_CYCLES = 1000,
    parameter int RT_W        = 16,
    parameter int LFSR_W      = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            react_i,
    input  logic            cmd_seq_i,
    input  logic            cmd_delay_i,
    output logic            trigger_o,
    output logic            en_o,
    output logic            lights_clr_o,
    output logic [RT_W-1:0] react_time_o,
    output logic            react_valid_o,
    output logic            false_start_o,
    output logic            busy_o
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    ctrl_state_t       state_q, state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [LFSR_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [RT_W-1:0]   rt_cnt_q, rt_cnt_d;
    logic [RT_W-1:0]   react_time_q, react_time_d;
    logic              trigger_q, trigger_d;
    logic              en_q, en_d;
    logic              lights_clr_q, lights_clr_d;
    logic              react_valid_q, react_valid_d;
    logic              false_start_q, false_start_d;
    logic              busy_q, busy_d;
    logic [LFSR_W-1:0] lfsr;
    logic              tick;
    logic              unused_cmd_seq;

    // The light FSM's sequence-phase flag is informational only
    assign unused_cmd_seq = cmd_seq_i;

    f1_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q_o   (lfsr)
    );

    assign tick = (tick_cnt_q == TW'(TICK_CYCLES - 1));

    // Next-state and registered-output logic; react always wins over ticks and cmd_delay
    always_comb begin
        state_d       = state_q;
        dly_cnt_d     = dly_cnt_q;
        rt_cnt_d      = rt_cnt_q;
        react_time_d  = react_time_q;
        trigger_d     = 1'b0;
        en_d          = 1'b0;
        react_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    trigger_d = 1'b1;
                    state_d   = SEQ;
                end
            end
            SEQ: begin
                if (react_i) begin
                    state_d = FAULT;
                end else if (cmd_delay_i) begin
                    dly_cnt_d = lfsr;
                    state_d   = DELAY;
                end else begin
                    en_d = tick;
                end
            end
            DELAY: begin
                if (react_i) begin
                    state_d = FAULT;
                end else if (tick) begin
                    if (dly_cnt_q == LFSR_W'(1)) begin
                        en_d     = 1'b1;
                        rt_cnt_d = '0;
                        state_d  = TIMING;
                    end else begin
                        dly_cnt_d = dly_cnt_q - LFSR_W'(1);
                    end
                end
            end
            TIMING: begin
                rt_cnt_d = (&rt_cnt_q) ? rt_cnt_q : rt_cnt_q + RT_W'(1);
                if (react_i) begin
                    react_time_d  = rt_cnt_q;
                    react_valid_d = 1'b1;
                    trigger_d     = 1'b1;
                    state_d       = IDLE;
                end
            end
            FAULT: begin
                if (start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tick_cnt_d    = (state_d != state_q || tick) ? '0 : tick_cnt_q + TW'(1);
        lights_clr_d  = (state_d == FAULT);
        false_start_d = (state_d == FAULT);
        busy_d        = (state_d != IDLE);
    end

    // State, counters and all outputs are registered; reset aborts instantly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            rt_cnt_q      <= '0;
            react_time_q  <= '0;
            trigger_q     <= 1'b0;
            en_q          <= 1'b0;
            lights_clr_q  <= 1'b0;
            react_valid_q <= 1'b0;
            false_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            rt_cnt_q      <= rt_cnt_d;
            react_time_q  <= react_time_d;
            trigger_q     <= trigger_d;
            en_q          <= en_d;
            lights_clr_q  <= lights_clr_d;
            react_valid_q <= react_valid_d;
            false_start_q <= false_start_d;
            busy_q        <= busy_d;
        end
    end

    assign trigger_o     = trigger_q;
    assign en_o          = en_q;
    assign lights_clr_o  = lights_clr_q;
    assign react_time_o  = react_time_q;
    assign react_valid_o = react_valid_q;
    assign false_start_o = false_start_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_f1_race_ctrl.sv
// tb_f1_race_ctrl: scoreboarded bench for f1_race_ctrl with a small light-FSM model alongside
module tb_f1_race_ctrl;

    localparam logic [2:0] TRG = 3'b100;
    localparam logic [2:0] ENP = 3'b010;
    localparam logic [2:0] RV  = 3'b001;

    typedef struct {
        int          c;
        logic [2:0]  p;
        logic [15:0] rt;
    } ev_t;

    typedef enum logic [1:0] {L_IDLE, L_SEQ, L_HOLD, L_OFF} ls_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic        cmd_seq, cmd_delay;
    logic        trigger, en, lights_clr, react_valid, false_start, busy;
    logic [15:0] react_time;
    logic [6:0]  m;
    ls_t         ls;
    int          lk;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];

    f1_race_ctrl #(.TICK_CYCLES(4), .RT_W(16), .LFSR_W(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .react_i       (react),
        .cmd_seq_i     (cmd_seq),
        .cmd_delay_i   (cmd_delay),
        .trigger_o     (trigger),
        .en_o          (en),
        .lights_clr_o  (lights_clr),
        .react_time_o  (react_time),
        .react_valid_o (react_valid),
        .false_start_o (false_start),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle index; at a negedge it names the current cycle
    always @(posedge clk) cyc <= cyc + 1;

    // Reference x^7+x^6+1 generator, tracking the value the controller would sample
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= 7'd1;
        else        m <= {m[5:0], m[6] ^ m[5]};

    // Minimal light FSM: 8 steps to HOLD, one more to OFF, trigger back to IDLE
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ls <= L_IDLE;
            lk <= 0;
        end else if (lights_clr) ls <= L_IDLE;
        else case (ls)
            L_IDLE: if (trigger) begin ls <= L_SEQ; lk <= 0; end
            L_SEQ:  if (en) begin lk <= lk + 1; if (lk == 7) ls <= L_HOLD; end
            L_HOLD: if (en) ls <= L_OFF;
            L_OFF:  if (trigger) ls <= L_IDLE;
            default: ls <= L_IDLE;
        endcase

    assign cmd_seq   = (ls == L_SEQ);
    assign cmd_delay = (ls == L_HOLD);

    // Monitor: every pulse cycle must match the next expected event exactly
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (trigger || en || react_valid)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse @%0d: got trg/en/rv=%b rt=%0h, required none", cyc, {trigger, en, react_valid}, react_time);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.p != {trigger, en, react_valid} || (react_valid && e.rt != react_time)) begin
                    n_fail++;
                    $display("FAIL pulse: got @%0d trg/en/rv=%b rt=%0h, required @%0d %b rt=%0h", cyc, {trigger, en, react_valid}, react_time, e.c, e.p, e.rt);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p, input logic [15:0] rt);
        ev_t e;
        e.c  = c;
        e.p  = p;
        e.rt = rt;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press();
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a race: trigger one cycle later, then en one cycle after every 4-cycle tick
    task automatic race_start(input int n_en, output int s);
        s = cyc;
        push(s + 1, TRG, 16'd0);
        for (int k = 1; k <= n_en; k++) push(s + 4 * k + 1, ENP, 16'd0);
        pulse_start();
    endtask

    // Clear a latched false start and confirm the controller is idle again
    task automatic clear_fault(input string nm);
        pulse_start();
        @(negedge clk);
        chk({nm, "_fs_clr"}, {31'd0, false_start}, 0);
        chk({nm, "_lc_clr"}, {31'd0, lights_clr}, 0);
        chk({nm, "_busy_clr"}, {31'd0, busy}, 0);
    endtask

    // Directed scenarios with hand-derived cycle offsets relative to the start cycle s
    initial begin
        int s;
        int d;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_outs", {26'd0, trigger, en, lights_clr, react_valid, false_start, busy}, 0);
        chk("idle_rt", {16'd0, react_time}, 0);
        chk("idle_light", {30'd0, ls}, L_IDLE);

        race_start(8, s);
        wait_until(s + 10);
        chk("seq_phase", {31'd0, cmd_seq}, 1);
        wait_until(s + 34);
        chk("cmd_delay_up", {31'd0, cmd_delay}, 1);
        chk("busy_seq", {31'd0, busy}, 1);
        d = int'(m);
        push(s + 35 + 4 * d, ENP, 16'd0);
        wait_until(s + 45 + 4 * d);
        chk("light_off", {30'd0, ls}, L_OFF);
        push(cyc + 1, TRG | RV, 16'd10);
        press();
        repeat (2) @(negedge clk);
        chk("busy_done", {31'd0, busy}, 0);
        chk("rt_10", {16'd0, react_time}, 10);
        chk("light_idle", {30'd0, ls}, L_IDLE);

        race_start(3, s);
        wait_until(s + 14);
        press();
        wait_until(s + 24);
        chk("fs_seq", {31'd0, false_start}, 1);
        chk("lc_seq", {31'd0, lights_clr}, 1);
        chk("light_cleared", {30'd0, ls}, L_IDLE);
        chk("rt_kept", {16'd0, react_time}, 10);
        clear_fault("seq");

        race_start(8, s);
        wait_until(s + 34);
        chk("cmd_delay_2", {31'd0, cmd_delay}, 1);
        press();
        repeat (40) @(negedge clk);
        chk("fs_react_vs_delay", {31'd0, false_start}, 1);
        clear_fault("rvd");

        race_start(8, s);
        wait_until(s + 34);
        d = int'(m);
        wait_until(s + 34 + 4 * d);
        press();
        wait_until(s + 40 + 4 * d);
        chk("fs_final_tick", {31'd0, false_start}, 1);
        chk("lc_final_tick", {31'd0, lights_clr}, 1);
        clear_fault("ftk");

        race_start(8, s);
        wait_until(s + 34);
        d = int'(m);
        push(s + 35 + 4 * d, ENP, 16'd0);
        wait_until(s + 35 + 4 * d + 70000);
        push(cyc + 1, TRG | RV, 16'hFFFF);
        press();
        @(negedge clk);
        chk("rt_saturated", {16'd0, react_time}, 32'hFFFF);

        race_start(8, s);
        wait_until(s + 36);
        chk("busy_delay", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {26'd0, trigger, en, lights_clr, react_valid, false_start, busy}, 0);
        chk("rst_rt", {16'd0, react_time}, 0);
        chk("rst_lfsr", {25'd0, dut.u_lfsr.q_o}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_outs", {26'd0, trigger, en, lights_clr, react_valid, false_start, busy}, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
